// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU: command encoding, control word,
// ALU argument/return payloads.
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        COMP  = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        XNOR  = 3'd5,
        RSHFT = 3'd6
    } AluCmd;

    typedef struct packed {
        AluCmd cmd;
        logic  b_inv;
        logic  carry_disable;
        logic  carry_in;
    } AluCtrl;

    typedef struct packed {
        AluCtrl                ctrl;
        logic [NIBBLE_W-1:0]   d1;
        logic [NIBBLE_W-1:0]   d2;
    } AluArgs;

    typedef struct packed {
        logic [NIBBLE_W-1:0]   res;
        logic                  carry_out;
    } AluRet;

endpackage

// File: rtl/alu.sv
// Combinational single-nibble ALU.
// Ports: args (ctrl + d1/d2 nibbles) -> ret (res nibble + carry_out).
// ctrl.carry_in carries the running carry; it is gated by ctrl.carry_disable.
module alu
    import alu_pkg::*;
(
    input  AluArgs args,
    output AluRet  ret
);

    logic [NIBBLE_W-1:0] b;
    logic                cin;
    logic [NIBBLE_W:0]   sum_add;
    logic [NIBBLE_W:0]   sum_comp;

    assign b        = args.ctrl.b_inv ? ~args.d2 : args.d2;
    assign cin      = args.ctrl.carry_in & ~args.ctrl.carry_disable;
    assign sum_add  = {1'b0, args.d1} + {1'b0, b} + (NIBBLE_W+1)'(cin);
    assign sum_comp = {1'b0, args.d1} + {1'b0, ~b} + (NIBBLE_W+1)'(cin);

    // Command decode
    always_comb begin
        ret.res       = '0;
        ret.carry_out = 1'b0;
        case (args.ctrl.cmd)
            ADD:   {ret.carry_out, ret.res} = sum_add;
            COMP:  {ret.carry_out, ret.res} = sum_comp;
            AND:   ret.res = args.d1 & b;
            OR:    ret.res = args.d1 | b;
            XOR:   ret.res = args.d1 ^ b;
            XNOR:  ret.res = ~(args.d1 ^ b);
            RSHFT: begin
                // Shift right by one, carry enters at the top, bit 0 leaves.
                ret.res       = {cin, args.d2[NIBBLE_W-1:1]};
                ret.carry_out = args.d2[0];
            end
            default: begin
                ret.res       = '0;
                ret.carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/check_if_0xF.sv
// All-ones detector for one nibble.
// Ports: in[3:0] -> ret = &in.
module check_if_0xF
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in,
    output logic                ret
);

    assign ret = &in;

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial ALU loop: processes a 32-bit word one nibble per clock,
// LSB->MSB (or MSB->LSB for RSHFT), with carry extension past the last
// significant nibble and optional equality-check mode.
// Ports:
//   clk, rst (sync, active-high)
//   loop_perm_to_count   0 = arm/preload, 1 = run
//   loop_nibbles_number  index of last significant nibble
//   ctrl                 AluCtrl command word
//   check_if_result_0xF  equality-check mode select (needs CHECK_0XF_EN)
//   word2_is_signed_and_negative  sign-extend B with ones past the last nibble
//   word1, word2         operands A, B
//   preinit_result       value loaded into result while armed
//   busy                 loop in progress
//   result, carry_out    registered result and carry / equality flag
// Config macro: CHECK_0XF_EN enables equality-check mode.
module loop_over_all_nibbles
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    loop_perm_to_count,
    input  logic [2:0]              loop_nibbles_number,
    input  AluCtrl                  ctrl,
    input  logic                    check_if_result_0xF,
    input  logic                    word2_is_signed_and_negative,
    input  logic [NIBBLES*4-1:0]    word1,
    input  logic [NIBBLES*4-1:0]    word2,
    input  logic [NIBBLES*4-1:0]    preinit_result,
    output logic                    busy,
    output logic [NIBBLES*4-1:0]    result,
    output logic                    carry_out
);

    localparam int unsigned WORD_W = NIBBLES * NIBBLE_W;

    logic [3:0]        counter_q;
    logic              was_last_q;
    logic [WORD_W-1:0] result_q;
    logic              carry_q;

    logic [2:0]        idx_c;
    logic              reverse_c;
    logic              last_nibble_c;
    logic              done_c;
    logic              chk_mode_c;
    logic              is_f_c;
    AluArgs            alu_args;
    AluRet             alu_ret;

    assign idx_c     = counter_q[2:0];
    assign reverse_c = (ctrl.cmd == RSHFT);
    assign busy      = loop_perm_to_count & ~counter_q[3];
    assign result    = result_q;
    assign carry_out = carry_q;

    // ALU operands: current nibble, running carry, B inverted for sign extension
    always_comb begin
        alu_args            = '0;
        alu_args.ctrl       = ctrl;
        alu_args.ctrl.b_inv = ctrl.b_inv | (word2_is_signed_and_negative & was_last_q);
        alu_args.ctrl.carry_in = carry_q;
        alu_args.d1         = word1[{idx_c, 2'b00} +: NIBBLE_W];
        alu_args.d2         = word2[{idx_c, 2'b00} +: NIBBLE_W];
    end

    alu u_alu (
        .args (alu_args),
        .ret  (alu_ret)
    );

`ifdef CHECK_0XF_EN
    assign chk_mode_c = check_if_result_0xF;

    check_if_0xF u_check_if_0xF (
        .in  (alu_ret.res),
        .ret (is_f_c)
    );
`else
    wire unused_check_mode = &{1'b0, check_if_result_0xF};
    assign chk_mode_c = 1'b0;
    assign is_f_c     = 1'b1;
`endif

    assign last_nibble_c = reverse_c ? (idx_c == 3'd0) : (idx_c == loop_nibbles_number);

    // Loop termination: overflow or check miss win, sign extension keeps going
    always_comb begin
        done_c = 1'b0;
        if (counter_q[3] || (chk_mode_c && !is_f_c)) begin
            done_c = 1'b1;
        end else if (word2_is_signed_and_negative) begin
            done_c = 1'b0;
        end else begin
            done_c = was_last_q & ~alu_ret.carry_out;
        end
    end

    // Counter, last flag, result and carry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= 4'b1000;
            was_last_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
        end else if (!loop_perm_to_count) begin
            counter_q  <= reverse_c ? {1'b0, loop_nibbles_number} : 4'd0;
            was_last_q <= 1'b0;
            result_q   <= preinit_result;
            if (!chk_mode_c) begin
                carry_q <= ctrl.carry_in;
            end
        end else begin
            if (done_c) begin
                counter_q[3] <= 1'b1;
            end else begin
                // Reverse step from index 0 wraps into the overflow bit.
                counter_q <= reverse_c ? counter_q - 4'd1 : counter_q + 4'd1;
            end
            if (last_nibble_c) begin
                was_last_q <= 1'b1;
            end
            if (busy) begin
                result_q[{idx_c, 2'b00} +: NIBBLE_W] <= alu_ret.res;
                carry_q <= chk_mode_c ? is_f_c : alu_ret.carry_out;
            end
        end
    end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Directed self-checking bench for loop_over_all_nibbles.
module tb_loop_over_all_nibbles;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        loop_perm_to_count;
    logic [2:0]  loop_nibbles_number;
    AluCtrl      ctrl;
    logic        check_if_result_0xF;
    logic        word2_is_signed_and_negative;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] preinit_result;
    logic        busy;
    logic [31:0] result;
    logic        carry_out;

    int tests;
    int fails;
    int cyc;

    loop_over_all_nibbles #(.NIBBLES(8)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .loop_perm_to_count           (loop_perm_to_count),
        .loop_nibbles_number          (loop_nibbles_number),
        .ctrl                         (ctrl),
        .check_if_result_0xF          (check_if_result_0xF),
        .word2_is_signed_and_negative (word2_is_signed_and_negative),
        .word1                        (word1),
        .word2                        (word2),
        .preinit_result               (preinit_result),
        .busy                         (busy),
        .result                       (result),
        .carry_out                    (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Arm for one edge, then run until busy drops (bounded); returns running edges.
    task automatic run_op(input AluCmd cmd, input logic b_inv, input logic cdis,
                          input logic cin, input logic [2:0] nib, input logic chk,
                          input logic sneg, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] pre, input string tag, output int n);
        @(negedge clk);
        ctrl.cmd                     = cmd;
        ctrl.b_inv                   = b_inv;
        ctrl.carry_disable           = cdis;
        ctrl.carry_in                = cin;
        loop_nibbles_number          = nib;
        check_if_result_0xF          = chk;
        word2_is_signed_and_negative = sneg;
        word1                        = w1;
        word2                        = w2;
        preinit_result               = pre;
        loop_perm_to_count           = 1'b0;
        @(negedge clk);
        loop_perm_to_count = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) break;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        loop_perm_to_count = 1'b1;
        loop_nibbles_number = 3'd0;
        ctrl = '0;
        check_if_result_0xF = 1'b0;
        word2_is_signed_and_negative = 1'b0;
        word1 = 32'h1234_5678;
        word2 = 32'h1111_1111;
        preinit_result = 32'hDEAD_BEEF;

        // Reset state, with loop_perm_to_count held high
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(ADD, 0, 0, 0, 3'd0, 0, 0, 32'h00FF_0004, 32'h4, 32'h00FF_0004, "add_n0", cyc);
        check("add_n0_res", result, 32'h00FF_0008);
        check("add_n0_cyc", 32'(cyc), 32'd2);

        run_op(ADD, 0, 0, 0, 3'd7, 0, 0, 32'h0EFF_FFFF, 32'h1, 32'h0EFF_FFFF, "add_ripple", cyc);
        check("add_ripple_res", result, 32'h0F00_0000);
        check("add_ripple_co", 32'(carry_out), 32'd0);

        run_op(ADD, 0, 0, 0, 3'd7, 0, 0, 32'h2, 32'hFFFF_FFFD, 32'h2, "add_neg3", cyc);
        check("add_neg3_res", result, 32'hFFFF_FFFF);

        run_op(ADD, 0, 0, 0, 3'd2, 0, 1, 32'h0, 32'h800, 32'h0, "add_sext", cyc);
        check("add_sext_res", result, 32'hFFFF_F800);

        run_op(RSHFT, 0, 0, 0, 3'd7, 0, 0, 32'h0, 32'h0600_0000, 32'h0, "rshft", cyc);
        check("rshft_res", result, 32'h0300_0000);

        run_op(RSHFT, 0, 0, 1, 3'd3, 0, 0, 32'h0, 32'h0000_1234, 32'h0, "rshft_cin", cyc);
        check("rshft_cin_res", result, 32'h0000_891A);
        check("rshft_cin_cyc", 32'(cyc), 32'd4);

        run_op(COMP, 0, 0, 0, 3'd7, 0, 0, 32'h1234_1234, 32'h1234_1234, 32'h1234_1234, "comp", cyc);
        check("comp_res", result, 32'hFFFF_FFFF);

        run_op(ADD, 0, 0, 0, 3'd7, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, "add_ovf", cyc);
        check("add_ovf_res", result, 32'h0);
        check("add_ovf_co", 32'(carry_out), 32'd1);
        check("add_ovf_cyc", 32'(cyc), 32'd8);

        // Trailing cycle writes the nibble after the last significant one
        run_op(ADD, 0, 0, 0, 3'd3, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h1111_1111, "trail", cyc);
        check("trail_res", result, 32'h1113_3333);
        check("trail_cyc", 32'(cyc), 32'd5);

        run_op(ADD, 0, 0, 0, 3'd1, 0, 0, 32'hFF, 32'h1, 32'hFF, "cext", cyc);
        check("cext_res", result, 32'h100);
        check("cext_cyc", 32'(cyc), 32'd3);

        run_op(ADD, 0, 1, 1, 3'd0, 0, 0, 32'h1, 32'h1, 32'h1, "cdis", cyc);
        check("cdis_res", result, 32'h2);
        run_op(ADD, 0, 0, 1, 3'd0, 0, 0, 32'h1, 32'h1, 32'h1, "cin", cyc);
        check("cin_res", result, 32'h3);

        run_op(AND, 0, 0, 0, 3'd7, 0, 0, 32'hF0F0_A5A5, 32'hFF00_FF00, 32'h0, "and", cyc);
        check("and_res", result, 32'hF000_A500);
        run_op(OR, 0, 0, 0, 3'd7, 0, 0, 32'h0F0F_0000, 32'h00F0_F000, 32'h0, "or", cyc);
        check("or_res", result, 32'h0FFF_F000);

`ifdef CHECK_0XF_EN
        run_op(XNOR, 0, 0, 0, 3'd7, 1, 0, 32'h1234_1234, 32'h1234_1234, 32'h0, "chk_eq", cyc);
        check("chk_eq_co", 32'(carry_out), 32'd1);
        check("chk_eq_res", result, 32'hFFFF_FFFF);
        run_op(XNOR, 0, 0, 0, 3'd7, 1, 0, 32'h1234_1134, 32'h1234_1234, 32'h0, "chk_ne", cyc);
        check("chk_ne_co", 32'(carry_out), 32'd0);
        check("chk_ne_res", result, 32'h0000_0CFF);
        check("chk_ne_cyc", 32'(cyc), 32'd3);
`else
        // Check mode absent: select is ignored, full XNOR loop runs
        run_op(XNOR, 0, 0, 1, 3'd7, 1, 0, 32'h1234_1234, 32'h1234_1234, 32'h0, "chk_eq", cyc);
        check("chk_eq_co", 32'(carry_out), 32'd0);
        check("chk_eq_res", result, 32'hFFFF_FFFF);
        run_op(XNOR, 0, 0, 0, 3'd7, 1, 0, 32'h1234_1134, 32'h1234_1234, 32'h0, "chk_ne", cyc);
        check("chk_ne_res", result, 32'hFFFF_FCFF);
        check("chk_ne_cyc", 32'(cyc), 32'd8);
`endif

        // Reset mid-loop takes priority over running
        @(negedge clk);
        ctrl = '0;
        ctrl.carry_in = 1'b1;
        loop_nibbles_number = 3'd7;
        check_if_result_0xF = 1'b0;
        word2_is_signed_and_negative = 1'b0;
        word1 = 32'h1111_1111;
        word2 = 32'h2222_2222;
        preinit_result = 32'h1111_1111;
        loop_perm_to_count = 1'b0;
        @(negedge clk);
        loop_perm_to_count = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", result, 32'h0);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/loop_over_all_nibbles.md
LOOP_OVER_ALL_NIBBLES -- requirements
Module: loop_over_all_nibbles

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, word length in nibbles; only 8 is supported, with a 3-bit nibble index.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have loop_perm_to_count, input, 1; 0 = arm/preload, 1 = run loop.
REQ-005 SHALL have loop_nibbles_number, input, 3, index of the last significant nibble (0..7).
REQ-006 SHALL have ctrl, input, AluCtrl: cmd, b_inv, carry_disable, carry_in.
REQ-007 SHALL have check_if_result_0xF, input, 1, selects equality-check mode.
REQ-008 SHALL have word2_is_signed_and_negative, input, 1; word2 is a short negative signed value.
REQ-009 SHALL have word1, input, 32, operand A, normally equal to preinit_result.
REQ-010 SHALL have word2, input, 32, operand B.
REQ-011 SHALL have preinit_result, input, 32, value loaded into result while armed.
REQ-012 SHALL have busy, output, 1, loop in progress.
REQ-013 SHALL have result, output, 32, registered result.
REQ-014 SHALL have carry_out, output, 1; registered carry, or the equality flag in check mode.

Function
REQ-015 ALU commands, per nibble, with cin = carry register AND NOT carry_disable, and b = d2, or ~d2 when inverted:
- ADD: {co,res} = d1+b+cin
- COMP: {co,res} = d1+~b+cin, so A-B-1 with cin=0
- AND, OR, XOR, XNOR: bitwise, co=0
- RSHFT: res={cin,d2[3:1]}, co=d2[0]
REQ-016 Direction: RSHFT runs MSB to LSB; all other commands run LSB to MSB.
REQ-017 Counter: 4 bits, bit 3 is the overflow flag, bits 2:0 are the nibble index.
REQ-018 While armed (loop_perm_to_count=0), each cycle the block SHALL:
- load the counter with loop_nibbles_number for RSHFT, else 0;
- clear was_last;
- set result=preinit_result;
- set carry=ctrl.carry_in, except in check mode where carry is held.
REQ-019 last_nibble is true when the index equals loop_nibbles_number (forward) or equals 0 (reverse); was_last is set on the edge where last_nibble is true and the loop is running.
REQ-020 Combinational done flag:
- 1 if overflow, or if check mode is on and the nibble result is not 0xF;
- else 0 if word2_is_signed_and_negative;
- else was_last AND NOT co.
REQ-021 On each running edge: if not done, the counter steps by +1 (forward) or -1 (reverse); if done, only counter[3] is set to 1.
REQ-022 busy = loop_perm_to_count AND NOT counter[3].
REQ-023 While busy, each edge SHALL write result[index] = nibble result and carry = co; in check mode carry = (nibble result == 0xF) instead.
REQ-024 B SHALL be inverted when ctrl.b_inv is set, or when word2_is_signed_and_negative and was_last are both set (sign extension).
REQ-025 Carry past loop_nibbles_number SHALL extend the loop until co=0 or nibble 7 is passed.
REQ-026 Latency: one cycle per nibble, plus one extra trailing cycle that writes the next nibble from word1/word2.
REQ-027 When not busy, result and carry SHALL hold their values.

Reset
REQ-028 On rst=1: counter=4'b1000, was_last=0, result=0, carry=0, busy=0; rst SHALL take priority over loop_perm_to_count, including mid-loop.

Configuration
REQ-029 Macro CHECK_0XF_EN:
- when defined, equality-check mode and the check_if_0xF instance are present;
- when undefined, check_if_result_0xF is ignored (treated as 0) and the port remains.

Structure
REQ-030 Package alu_pkg SHALL hold:
- AluCmd enum, 3 bits: ADD=0, COMP=1, AND=2, OR=3, XOR=4, XNOR=5, RSHFT=6;
- AluCtrl struct;
- AluArgs struct {ctrl, d1[3:0], d2[3:0]};
- AluRet struct {res[3:0], carry_out}.
REQ-031 Sub-modules SHALL be alu (combinational nibble ALU, args to ret) and check_if_0xF (in[3:0] to ret = &in).

Verification
REQ-032 ADD, nibbles=0, preinit=word1=0x00FF0004, word2=4 -> result 0x00FF0008.
REQ-033 ADD, nibbles=7, word1=0x0EFFFFFF, word2=1 -> 0x0F000000; word1=0x00000002, word2=-3 -> 0xFFFFFFFF.
REQ-034 ADD, nibbles=2, signed_neg=1, preinit=word1=0, word2=0x800 -> 0xFFFFF800.
REQ-035 RSHFT, nibbles=7, word2=0x06000000 -> 0x03000000.
REQ-036 COMP, word1=word2=0x12341234 -> 0xFFFFFFFF.
REQ-037 Check mode XNOR on 0x12341234 vs 0x12341234 -> carry_out=1; 0x12341134 vs 0x12341234 -> carry_out=0 and the loop stops early at nibble 2.
